// File: rtl/snoop_bus_controller.sv
// Snooping bus stage: collects per-CPU coherence messages, arbitrates
// round-robin, broadcasts the winner, samples remote flush responses,
// sequences a memory write-back when a dirty remote copy is flushed and
// pulses done to the requester. One transaction in flight at a time.
module snoop_bus_controller #(
    parameter int NUM_CPU = 4,
    parameter int SRC_W   = 2,
    parameter int ADDR_W  = 8,
    parameter int WB_CYC  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CPU-1:0]        req,
    input  logic [2*NUM_CPU-1:0]      msg,
    input  logic [ADDR_W*NUM_CPU-1:0] addr,
    input  logic [NUM_CPU-1:0]        snoop_flush,
    output logic [NUM_CPU-1:0]        grant,
    output logic                      bus_valid,
    output logic [1:0]                bus_msg,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [SRC_W-1:0]          bus_src,
    output logic                      mem_wb,
    output logic [NUM_CPU-1:0]        done
);

    // Counter only needs to hold WB_CYC-1.
    localparam int CNT_W = (WB_CYC > 1) ? $clog2(WB_CYC) : 1;

    localparam logic [1:0] MSG_EMPTY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BCAST,
        ST_SNOOP,
        ST_WB,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [SRC_W-1:0]    rr_last_q, rr_last_d;
    logic [1:0]          lat_msg_q, lat_msg_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;
    logic [1:0]          bus_msg_q, bus_msg_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [SRC_W-1:0]    bus_src_q, bus_src_d;

    logic [1:0]          msg_arr  [NUM_CPU];
    logic [ADDR_W-1:0]   addr_arr [NUM_CPU];
    logic [NUM_CPU-1:0]  req_valid;
    logic                pick_found;
    logic [SRC_W-1:0]    pick_idx;
    logic [SRC_W-1:0]    cand;
    logic [NUM_CPU-1:0]  src_oh;
    logic                flush_hit;

    // Split the packed per-CPU buses; an empty message code means no request.
    always_comb begin
        for (int i = 0; i < NUM_CPU; i++) begin
            msg_arr[i]   = msg[2*i +: 2];
            addr_arr[i]  = addr[ADDR_W*i +: ADDR_W];
            req_valid[i] = req[i] && (msg[2*i +: 2] != MSG_EMPTY);
        end
    end

    // Round-robin search starting just after the last CPU served.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CPU; k++) begin
            cand = SRC_W'((int'(rr_last_q) + k) % NUM_CPU);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign src_oh    = {{(NUM_CPU-1){1'b0}}, 1'b1} << src_q;
    // The requester's own flush response never counts as a remote hit.
    assign flush_hit = |(snoop_flush & ~src_oh);

    // Transaction sequencer: next state and next register values.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        src_d      = src_q;
        rr_last_d  = rr_last_q;
        lat_msg_d  = lat_msg_q;
        lat_addr_d = lat_addr_q;
        wb_cnt_d   = wb_cnt_q;
        bus_msg_d  = bus_msg_q;
        bus_addr_d = bus_addr_q;
        bus_src_d  = bus_src_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    src_d      = pick_idx;
                    lat_msg_d  = msg_arr[pick_idx];
                    lat_addr_d = addr_arr[pick_idx];
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Load the bus registers so they are visible during BROADCAST
                // and then hold until the next broadcast.
                bus_msg_d  = lat_msg_q;
                bus_addr_d = lat_addr_q;
                bus_src_d  = src_q;
                state_d    = ST_BCAST;
            end
            ST_BCAST: begin
                state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                // Only read/write misses (code 0x) fetch a dirty remote copy;
                // an invalidate comes from shared, so a flush there is ignored.
                if (flush_hit && !lat_msg_q[1]) begin
                    wb_cnt_d = CNT_W'(WB_CYC - 1);
                    state_d  = ST_WB;
                end else begin
                    state_d  = ST_DONE;
                end
            end
            ST_WB: begin
                if (wb_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wb_cnt_d = wb_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                rr_last_d = src_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so none depends on inputs.
    assign grant     = (state_q != ST_IDLE) ? src_oh : '0;
    assign bus_valid = (state_q == ST_BCAST);
    assign mem_wb    = (state_q == ST_WB);
    assign done      = (state_q == ST_DONE) ? src_oh : '0;
    assign bus_msg   = bus_msg_q;
    assign bus_addr  = bus_addr_q;
    assign bus_src   = bus_src_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            rr_last_q  <= SRC_W'(NUM_CPU - 1);
            lat_msg_q  <= '0;
            lat_addr_q <= '0;
            wb_cnt_q   <= '0;
            bus_msg_q  <= '0;
            bus_addr_q <= '0;
            bus_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rr_last_q  <= rr_last_d;
            lat_msg_q  <= lat_msg_d;
            lat_addr_q <= lat_addr_d;
            wb_cnt_q   <= wb_cnt_d;
            bus_msg_q  <= bus_msg_d;
            bus_addr_q <= bus_addr_d;
            bus_src_q  <= bus_src_d;
        end
    end

endmodule
